// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment scan controller.
// Splits the system clock into one slot per digit and scans the digits from
// DIGITS-1 (leftmost) down to 0. The digit codes go out on one shared code bus,
// and each digit has its own active-low enable. All display inputs are
// snapshotted once per frame, so a value never tears on screen. On top of that
// the block does leading-zero blanking, per-digit blinking and a counter mode.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       1 = scan runs, 0 = scan frozen and all digits off
//   data_in      packed digit codes, digit i at [i*DIGIT_W +: DIGIT_W]
//   mode_sel     0 = data_in, 1 = counter_num on digit 0 and zero elsewhere
//   counter_num  value shown in counter mode
//   lz_blank     suppress leading zeros
//   blink_mask   bit i = digit i blinks
//   ssd_ctl      active-low digit enables (registered)
//   ssd_in       code of the enabled digit (registered)
//   frame_tick   one-cycle pulse with the first output of each frame
//   digit_idx    digit currently being scanned (state register)

// Per-digit value select and blink gating.
module ssd_scan_lane #(
  parameter int DIGIT_W = 4,
  parameter int LANE    = 0
) (
  input  logic               mode,
  input  logic [DIGIT_W-1:0] data,
  input  logic [DIGIT_W-1:0] cnt,
  input  logic               blink_en,
  output logic [DIGIT_W-1:0] val,
  output logic               blink_off
);
  always_comb begin
    val = data;
    if (mode) val = (LANE == 0) ? cnt : '0;
  end

  assign blink_off = blink_en;
endmodule

module ssd_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int DIGIT_W      = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [DIGITS*DIGIT_W-1:0]   data_in,
  input  logic                        mode_sel,
  input  logic [DIGIT_W-1:0]          counter_num,
  input  logic                        lz_blank,
  input  logic [DIGITS-1:0]           blink_mask,
  output logic [DIGITS-1:0]           ssd_ctl,
  output logic [DIGIT_W-1:0]          ssd_in,
  output logic                        frame_tick,
  output logic [$clog2(DIGITS)-1:0]   digit_idx
);
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam int BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRESC_W-1:0]              presc;
  logic [BC_W-1:0]                 bcnt;
  logic                            ph;
  logic [DIGITS-1:0][DIGIT_W-1:0]  snap_data;
  logic                            snap_mode;
  logic [DIGIT_W-1:0]              snap_cnt;
  logic                            snap_lz;
  logic [DIGITS-1:0]               snap_mask;
  logic                            wrap_q;

  logic [DIGITS-1:0][DIGIT_W-1:0]  lane_val;
  logic [DIGITS-1:0]               lane_blink;
  logic [DIGITS-1:0]               slot_blank;
  logic                            slot_tick, wrap;

  assign slot_tick = enable && (presc == PRESC_W'(REFRESH_DIV - 1));
  assign wrap      = slot_tick && (digit_idx == '0);

  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    ssd_scan_lane #(.DIGIT_W(DIGIT_W), .LANE(i)) u_lane (
      .mode     (snap_mode),
      .data     (snap_data[i]),
      .cnt      (snap_cnt),
      .blink_en (ph && snap_mask[i]),
      .val      (lane_val[i]),
      .blink_off(lane_blink[i])
    );
  end

  // Walk from the leftmost digit down. run stays 1 while every digit seen so
  // far is zero. Digit 0 is exempt, so an all-zero value still shows one 0.
  always_comb begin
    logic run;
    run        = 1'b1;
    slot_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run           = run && (lane_val[i] == '0);
      slot_blank[i] = (snap_lz && (i != 0) && run) || lane_blink[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      digit_idx  <= IDX_W'(DIGITS - 1);
      bcnt       <= '0;
      ph         <= 1'b0;
      snap_data  <= '0;
      snap_mode  <= 1'b0;
      snap_cnt   <= '0;
      snap_lz    <= 1'b0;
      snap_mask  <= '0;
      wrap_q     <= 1'b0;
      frame_tick <= 1'b0;
      ssd_ctl    <= '1;
      ssd_in     <= '0;
    end else begin
      if (enable) begin
        if (slot_tick) begin
          presc     <= '0;
          digit_idx <= (digit_idx == '0) ? IDX_W'(DIGITS - 1) : digit_idx - 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
        wrap_q <= wrap;
      end

      if (wrap) begin
        snap_data <= data_in;
        snap_mode <= mode_sel;
        snap_cnt  <= counter_num;
        snap_lz   <= lz_blank;
        snap_mask <= blink_mask;
        if (bcnt == BC_W'(BLINK_FRAMES - 1)) begin
          bcnt <= '0;
          ph   <= ~ph;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end

      // The outputs lag the state by one cycle. Delaying the wrap one more
      // stage lines frame_tick up with the first output of the new frame.
      frame_tick <= enable && wrap_q;

      if (!enable || slot_blank[digit_idx]) begin
        ssd_ctl <= '1;
        ssd_in  <= '0;
      end else begin
        ssd_ctl <= ~(DIGITS'(1) << digit_idx);
        ssd_in  <= lane_val[digit_idx];
      end
    end
  end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIGITS=4, REFRESH_DIV=4 and
// BLINK_FRAMES=2. Expected values are hand-written per frame.
module tb_ssd_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic        mode_sel = 1'b0;
  logic [3:0]  counter_num = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  ssd_ctl;
  logic [3:0]  ssd_in;
  logic        frame_tick;
  logic [1:0]  digit_idx;

  int n_run = 0;
  int n_fail = 0;

  ssd_scan_ctrl #(.DIGITS(4), .DIGIT_W(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
    .mode_sel(mode_sel), .counter_num(counter_num), .lz_blank(lz_blank),
    .blink_mask(blink_mask), .ssd_ctl(ssd_ctl), .ssd_in(ssd_in),
    .frame_tick(frame_tick), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of the first cycle of a frame. ectl and ein hold
  // the expected values per digit as {d3,d2,d1,d0} nibbles. At cycle chg the
  // bench writes cval to data_in (chg < 0 means no write). The task returns
  // at the negedge of the first cycle of the next frame.
  task automatic run_frame(input string tag, input logic [15:0] ectl,
                           input logic [15:0] ein, input logic etick,
                           input int chg, input logic [15:0] cval);
    for (int s = 0; s < 16; s++) begin
      int d;
      d = 3 - s / 4;
      chk({tag, "_ctl"}, 32'(ssd_ctl), 32'(ectl[d*4 +: 4]));
      chk({tag, "_in"},  32'(ssd_in),  32'(ein[d*4 +: 4]));
      chk({tag, "_tick"}, 32'(frame_tick), 32'((s == 0) ? etick : 1'b0));
      chk({tag, "_idx"}, 32'(digit_idx), 32'(3 - ((s + 1) % 16) / 4));
      if (s == chg) data_in = cval;
      @(negedge clk);
    end
  endtask

  initial begin
    data_in = 16'h1234;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'(ssd_ctl), 32'hF);
    chk("rst_in", 32'(ssd_in), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h3);

    rst_n = 1'b1;
    @(negedge clk);
    run_frame("f0_reset", 16'h7BDE, 16'h0000, 1'b0, -1, 16'h0);
    lz_blank = 1'b1; data_in = 16'h0050;
    run_frame("f1_1234", 16'h7BDE, 16'h1234, 1'b1, -1, 16'h0);
    data_in = 16'h0000;
    run_frame("f2_lz0050", 16'hFFDE, 16'h0050, 1'b1, -1, 16'h0);
    lz_blank = 1'b0; mode_sel = 1'b1; counter_num = 4'h7;
    run_frame("f3_lz0000", 16'hFFFE, 16'h0000, 1'b1, -1, 16'h0);
    lz_blank = 1'b1;
    run_frame("f4_cnt", 16'h7BDE, 16'h0007, 1'b1, -1, 16'h0);
    mode_sel = 1'b0; lz_blank = 1'b0; data_in = 16'h1234; blink_mask = 4'b0001;
    run_frame("f5_cntlz", 16'hFFFE, 16'h0007, 1'b1, -1, 16'h0);
    run_frame("f6_blink", 16'h7BDF, 16'h1230, 1'b1, -1, 16'h0);
    run_frame("f7_blink", 16'h7BDF, 16'h1230, 1'b1, -1, 16'h0);
    blink_mask = 4'b0000;
    run_frame("f8_unblink", 16'h7BDE, 16'h1234, 1'b1, -1, 16'h0);
    run_frame("f9_tearfree", 16'h7BDE, 16'h1234, 1'b1, 6, 16'h9876);
    run_frame("f10_9876", 16'h7BDE, 16'h9876, 1'b1, -1, 16'h0);

    // Frame 11: run into the middle of slot 1, then freeze the scan.
    repeat (9) @(negedge clk);
    chk("pre_dis_ctl", 32'(ssd_ctl), 32'hD);
    chk("pre_dis_in", 32'(ssd_in), 32'h7);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_ctl", 32'(ssd_ctl), 32'hF);
      chk("dis_in", 32'(ssd_in), 32'h0);
      chk("dis_idx", 32'(digit_idx), 32'h1);
      chk("dis_tick", 32'(frame_tick), 32'h0);
    end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("resume_ctl", 32'(ssd_ctl), 32'hD);
      chk("resume_in", 32'(ssd_in), 32'h7);
    end
    @(negedge clk);
    chk("resume_d0_ctl", 32'(ssd_ctl), 32'hE);
    chk("resume_d0_in", 32'(ssd_in), 32'h6);

    // Assert reset away from any clock edge. The outputs must clear at once.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 32'(ssd_ctl), 32'hF);
    chk("arst_in", 32'(ssd_in), 32'h0);
    chk("arst_idx", 32'(digit_idx), 32'h3);
    chk("arst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("r0_reset", 16'h7BDE, 16'h0000, 1'b0, -1, 16'h0);
    run_frame("r1_9876", 16'h7BDE, 16'h9876, 1'b1, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
